// File: rtl/cpu_multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS CPU: sequences the shared datapath
// per opcode, stalls on mem_ready, and counts retired instructions.
module cpu_multicycle_ctrl #(
  parameter int unsigned INSTR_CNT_W = 32
) (
  input  logic                   fast_clk,
  input  logic                   reset,
  input  logic [5:0]             opcode,
  input  logic                   zero,
  input  logic                   mem_ready,
  input  logic                   halt,
  output logic                   pc_write,
  output logic                   pc_write_cond,
  output logic                   i_or_d,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   ir_write,
  output logic                   mem_to_reg,
  output logic                   reg_dst,
  output logic                   reg_write,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [1:0]             alu_op,
  output logic [1:0]             pc_source,
  output logic [3:0]             state,
  output logic                   illegal,
  output logic [INSTR_CNT_W-1:0] instr_count
);

  localparam logic [3:0] FETCH     = 4'd0;
  localparam logic [3:0] DECODE    = 4'd1;
  localparam logic [3:0] MEM_ADDR  = 4'd2;
  localparam logic [3:0] MEM_READ  = 4'd3;
  localparam logic [3:0] MEM_WB    = 4'd4;
  localparam logic [3:0] MEM_WRITE = 4'd5;
  localparam logic [3:0] R_EXEC    = 4'd6;
  localparam logic [3:0] R_WB      = 4'd7;
  localparam logic [3:0] BRANCH    = 4'd8;
  localparam logic [3:0] JUMP      = 4'd9;
  localparam logic [3:0] ADDI_EXEC = 4'd10;
  localparam logic [3:0] ADDI_WB   = 4'd11;
  localparam logic [3:0] HALTED    = 4'd12;
  localparam logic [3:0] ILLEGAL   = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  logic [3:0]             state_q;
  logic [3:0]             state_d;
  logic [5:0]             opcode_q;
  logic                   illegal_q;
  logic [INSTR_CNT_W-1:0] count_q;
  logic                   retire;

  // Raw strobes before reset gating
  logic pc_write_raw, pc_write_cond_raw, mem_read_raw, mem_write_raw;
  logic ir_write_raw, reg_write_raw;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH: begin
        if (halt)           state_d = HALTED;
        else if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        unique case (opcode)
          OP_RTYPE:      state_d = R_EXEC;
          OP_LW, OP_SW:  state_d = MEM_ADDR;
          OP_BEQ:        state_d = BRANCH;
          OP_J:          state_d = JUMP;
          OP_ADDI:       state_d = ADDI_EXEC;
          default:       state_d = ILLEGAL;
        endcase
      end
      MEM_ADDR:  state_d = (opcode_q == OP_LW) ? MEM_READ : MEM_WRITE;
      MEM_READ:  if (mem_ready) state_d = MEM_WB;
      MEM_WB:    state_d = FETCH;
      MEM_WRITE: if (mem_ready) state_d = FETCH;
      R_EXEC:    state_d = R_WB;
      R_WB:      state_d = FETCH;
      BRANCH:    state_d = FETCH;
      JUMP:      state_d = FETCH;
      ADDI_EXEC: state_d = ADDI_WB;
      ADDI_WB:   state_d = FETCH;
      HALTED:    if (!halt) state_d = FETCH;
      ILLEGAL:   state_d = ILLEGAL;
      default:   state_d = FETCH;
    endcase
  end

  always_comb begin
    retire = 1'b0;
    if (state_d == FETCH) begin
      unique case (state_q)
        MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP, ADDI_WB: retire = 1'b1;
        default:                                        retire = 1'b0;
      endcase
    end
  end

  always_ff @(posedge fast_clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH;
      opcode_q  <= '0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) opcode_q <= opcode;
      if (state_d == ILLEGAL) illegal_q <= 1'b1;
      if (retire) count_q <= count_q + 1'b1;
    end
  end

  always_comb begin
    pc_write_raw      = 1'b0;
    pc_write_cond_raw = 1'b0;
    mem_read_raw      = 1'b0;
    mem_write_raw     = 1'b0;
    ir_write_raw      = 1'b0;
    reg_write_raw     = 1'b0;
    i_or_d            = 1'b0;
    mem_to_reg        = 1'b0;
    reg_dst           = 1'b0;
    alu_src_a         = 1'b0;
    alu_src_b         = 2'b00;
    alu_op            = 2'b00;
    pc_source         = 2'b00;
    unique case (state_q)
      FETCH: begin
        // halt wins over mem_ready: a halting fetch must not touch IR or PC
        mem_read_raw = !halt;
        ir_write_raw = mem_ready && !halt;
        pc_write_raw = mem_ready && !halt;
        alu_src_b    = 2'b01;
      end
      DECODE: alu_src_b = 2'b11;
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEM_READ: begin
        mem_read_raw = 1'b1;
        i_or_d       = 1'b1;
      end
      MEM_WB: begin
        reg_write_raw = 1'b1;
        mem_to_reg    = 1'b1;
      end
      MEM_WRITE: begin
        mem_write_raw = 1'b1;
        i_or_d        = 1'b1;
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      R_WB: begin
        reg_write_raw = 1'b1;
        reg_dst       = 1'b1;
      end
      BRANCH: begin
        alu_src_a         = 1'b1;
        alu_op            = 2'b01;
        pc_write_cond_raw = 1'b1;
        pc_source         = 2'b01;
      end
      JUMP: begin
        pc_write_raw = 1'b1;
        pc_source    = 2'b10;
      end
      ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      ADDI_WB: reg_write_raw = 1'b1;
      default: ;
    endcase
  end

  assign pc_write      = pc_write_raw      && reset;
  assign pc_write_cond = pc_write_cond_raw && reset;
  assign mem_read      = mem_read_raw      && reset;
  assign mem_write     = mem_write_raw     && reset;
  assign ir_write      = ir_write_raw      && reset;
  assign reg_write     = reg_write_raw     && reset;
  assign state         = state_q;
  assign illegal       = illegal_q;
  assign instr_count   = count_q;

endmodule

// File: tb/tb_cpu_multicycle_ctrl.sv
// Directed-vector bench for cpu_multicycle_ctrl with a 4-bit retire counter.
module tb_cpu_multicycle_ctrl;

  localparam int unsigned CW = 4;

  logic          fast_clk = 1'b0;
  logic          reset;
  logic [5:0]    opcode;
  logic          zero;
  logic          mem_ready;
  logic          halt;
  logic          pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic          mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
  logic [1:0]    alu_src_b, alu_op, pc_source;
  logic [3:0]    state;
  logic [CW-1:0] instr_count;

  int vectors = 0;
  int miscompares = 0;

  cpu_multicycle_ctrl #(.INSTR_CNT_W(CW)) dut (
    .fast_clk(fast_clk), .reset(reset), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .halt(halt), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .mem_to_reg(mem_to_reg),
    .reg_dst(reg_dst), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .state(state), .illegal(illegal), .instr_count(instr_count)
  );

  always #5 fast_clk = ~fast_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and check the state entered
  task automatic step(input string tag, input logic [3:0] exp_state);
    @(posedge fast_clk);
    #1;
    check(tag, {28'd0, state}, {28'd0, exp_state});
  endtask

  function automatic logic [5:0] strobes();
    return {pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write};
  endfunction

  initial begin
    reset = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b1; halt = 1'b0;
    #12;
    check("rst_state", {28'd0, state}, 32'd0);
    check("rst_count", {28'd0, instr_count}, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    check("rst_ir_write", {31'd0, ir_write}, 32'd0);
    check("rst_pc_write", {31'd0, pc_write}, 32'd0);
    @(negedge fast_clk);
    reset = 1'b1;
    #1;
    check("fetch_decode", {26'd0, mem_read, ir_write, pc_write, alu_src_b, i_or_d},
          {26'd0, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0});

    // FETCH wait: stays, no IR/PC load
    mem_ready = 1'b0;
    #1;
    check("fetch_wait_ir", {31'd0, ir_write}, 32'd0);
    step("fetch_wait_state", 4'd0);
    check("fetch_wait_rd", {31'd0, mem_read}, 32'd1);
    mem_ready = 1'b1;

    // R-type
    opcode = 6'b000000;
    step("r_dec", 4'd1);
    check("dec_srcb", {30'd0, alu_src_b}, 32'd3);
    step("r_exec", 4'd6);
    check("r_exec_ctl", {27'd0, alu_src_a, alu_src_b, alu_op}, {27'd0, 1'b1, 2'b00, 2'b10});
    step("r_wb", 4'd7);
    check("r_wb_ctl", {29'd0, reg_write, reg_dst, mem_to_reg}, 32'b110);
    step("r_done", 4'd0);
    check("cnt_after_r", {28'd0, instr_count}, 32'd1);

    // lw
    opcode = 6'b100011;
    step("lw_dec", 4'd1);
    step("lw_addr", 4'd2);
    check("lw_addr_ctl", {29'd0, alu_src_a, alu_src_b}, {29'd0, 1'b1, 2'b10});
    step("lw_read", 4'd3);
    check("lw_read_ctl", {30'd0, mem_read, i_or_d}, 32'b11);
    step("lw_wb", 4'd4);
    check("lw_wb_ctl", {29'd0, reg_write, mem_to_reg, reg_dst}, 32'b110);
    step("lw_done", 4'd0);
    check("cnt_after_lw", {28'd0, instr_count}, 32'd2);

    // sw with three wait cycles in MEM_WRITE
    opcode = 6'b101011;
    step("sw_dec", 4'd1);
    step("sw_addr", 4'd2);
    step("sw_write", 4'd5);
    mem_ready = 1'b0;
    check("sw_wr0", {31'd0, mem_write}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step("sw_wait_state", 4'd5);
      check("sw_wait_wr", {30'd0, mem_write, i_or_d}, 32'b11);
      check("sw_wait_cnt", {28'd0, instr_count}, 32'd2);
    end
    mem_ready = 1'b1;
    step("sw_done", 4'd0);
    check("cnt_after_sw", {28'd0, instr_count}, 32'd3);

    // beq
    opcode = 6'b000100; zero = 1'b1;
    step("beq_dec", 4'd1);
    step("beq_br", 4'd8);
    check("beq_ctl", {27'd0, pc_write_cond, alu_op, pc_source}, {27'd0, 1'b1, 2'b01, 2'b01});
    step("beq_done", 4'd0);

    // j
    opcode = 6'b000010;
    step("j_dec", 4'd1);
    step("j_jump", 4'd9);
    check("j_ctl", {29'd0, pc_write, pc_source}, {29'd0, 1'b1, 2'b10});
    step("j_done", 4'd0);
    check("cnt_after_j", {28'd0, instr_count}, 32'd5);

    // halt in FETCH takes precedence over mem_ready
    halt = 1'b1;
    #1;
    check("halt_strobes", {26'd0, strobes()}, 32'd0);
    step("halt_enter", 4'd12);
    check("halted_strobes", {26'd0, strobes()}, 32'd0);
    step("halt_stay", 4'd12);
    halt = 1'b0;
    step("halt_exit", 4'd0);
    check("halt_exit_ir", {31'd0, ir_write}, 32'd1);
    check("cnt_after_halt", {28'd0, instr_count}, 32'd5);

    // illegal opcode, sticky
    opcode = 6'b111111;
    step("ill_dec", 4'd1);
    step("ill_enter", 4'd13);
    check("ill_flag", {31'd0, illegal}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(posedge fast_clk);
      #1;
      check("ill_hold", {26'd0, strobes(), state, illegal}, {26'd0, 6'd0, 4'd13, 1'b1});
    end
    reset = 1'b0;
    #1;
    check("ill_rst_flag", {31'd0, illegal}, 32'd0);
    check("ill_rst_state", {28'd0, state}, 32'd0);
    check("ill_rst_cnt", {28'd0, instr_count}, 32'd0);
    @(negedge fast_clk);
    reset = 1'b1;

    // 17 jumps through a 4-bit counter: 17 mod 16 = 1
    opcode = 6'b000010;
    for (int i = 0; i < 17; i++) begin
      step("wrap_dec", 4'd1);
      step("wrap_jump", 4'd9);
      step("wrap_fetch", 4'd0);
      if (i == 14) check("wrap_pre", {28'd0, instr_count}, 32'd15);
      if (i == 15) check("wrap_zero", {28'd0, instr_count}, 32'd0);
    end
    check("wrap_cnt", {28'd0, instr_count}, 32'd1);

    // async reset while waiting in MEM_READ
    opcode = 6'b100011;
    step("ar_dec", 4'd1);
    step("ar_addr", 4'd2);
    step("ar_read", 4'd3);
    mem_ready = 1'b0;
    step("ar_wait", 4'd3);
    #2;
    reset = 1'b0;
    #1;
    check("ar_state", {28'd0, state}, 32'd0);
    check("ar_cnt", {28'd0, instr_count}, 32'd0);
    check("ar_strobes", {26'd0, strobes()}, 32'd0);
    @(negedge fast_clk);
    reset = 1'b1;
    mem_ready = 1'b1;
    step("ar_recover", 4'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_multicycle_ctrl.md
# cpu_multicycle_ctrl

Main control FSM for the multi-cycle MIPS CPU that follows `cpuSingleCycle`. It sequences the shared datapath (single memory port, one ALU, IR, PC) through fetch/decode/execute/memory/writeback steps per opcode. It stalls on a memory-ready handshake and counts retired instructions. It sits beside the datapath in the CPU top, driven by the same clock.

## Interface
- `INSTR_CNT_W`, default 32: width of the retired-instruction counter.
- `fast_clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `opcode` in 6: IR[31:26]; sampled only in DECODE.
- `zero` in 1: ALU zero flag; sampled only in BRANCH.
- `mem_ready` in 1: memory completes the current access this cycle.
- `halt` in 1: request to stop before the next fetch.
- `pc_write` out 1: unconditional PC load.
- `pc_write_cond` out 1: PC load qualified by `zero`, used by the datapath.
- `i_or_d` out 1: memory address source (0 = PC, 1 = ALUOut).
- `mem_read` out 1: memory read strobe.
- `mem_write` out 1: memory write strobe.
- `ir_write` out 1: IR load.
- `mem_to_reg` out 1: register write data source (1 = MDR).
- `reg_dst` out 1: destination register (1 = rd, 0 = rt).
- `reg_write` out 1: register file write.
- `alu_src_a` out 1: ALU A source (0 = PC, 1 = A).
- `alu_src_b` out 2: ALU B source (00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm<<2).
- `alu_op` out 2: ALU operation (00 add, 01 sub, 10 funct).
- `pc_source` out 2: next PC source (00 ALU, 01 ALUOut, 10 jump target).
- `state` out 4: current state encoding, for debug.
- `illegal` out 1: an unsupported opcode was decoded.
- `instr_count` out INSTR_CNT_W: number of retired instructions.

## Operation
- State encodings:
  - FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5.
  - R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11.
  - HALTED=12, ILLEGAL=13.
- Outputs are Moore decodes of `state`, except that every PC, IR and MDR update in a memory state is gated by `mem_ready`. Any output not listed for a state is 0.
- FETCH (halt=0): drives `mem_read`, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - `ir_write` and `pc_write` follow `mem_ready`.
  - Moves to DECODE when mem_ready=1; otherwise stays.
- FETCH with halt=1, sampled on entry cycle or any wait cycle: goes to HALTED with no strobes asserted that cycle.
- HALTED: all strobes 0; returns to FETCH when halt=0.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
  - 000000 → R_EXEC
  - 100011 (lw) or 101011 (sw) → MEM_ADDR
  - 000100 (beq) → BRANCH
  - 000010 (j) → JUMP
  - 001000 (addi) → ADDI_EXEC
  - any other → ILLEGAL
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEM_READ for lw, MEM_WRITE for sw; the opcode is held in a register captured in DECODE.
- MEM_READ: mem_read=1, i_or_d=1. Moves to MEM_WB on mem_ready; otherwise waits.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Then FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. Moves to FETCH on mem_ready; otherwise waits with mem_write held high.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Then R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Then FETCH.
- JUMP: pc_write=1, pc_source=10. Then FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00. Then ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Then FETCH.
- ILLEGAL: all strobes 0, illegal=1. Sticky until reset.
- `instr_count` increments by 1 on every transition into FETCH from MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP or ADDI_WB. It wraps modulo 2^INSTR_CNT_W (all-ones → 0).

## Timing
- Reset (reset=0), asynchronous:
  - state=FETCH, instr_count=0, illegal=0, latched opcode=0.
  - Outputs then follow FETCH decode: mem_read=1, alu_src_b=01, all else 0; ir_write and pc_write = mem_ready ANDed with reset deasserted.
- No strobes are asserted while reset=0.
- Reset asserted mid-instruction, including during a memory wait: the FSM aborts immediately to FETCH and the counter clears.
- Cycle counts with mem_ready=1 throughout:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each cycle with mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle. During these waits no other output changes.
- halt takes precedence over mem_ready in FETCH.

## Test plan
- Release reset with mem_ready=1 and run R-type then lw.
  - R-type: states 0,1,6,7,0 with reg_dst=1 in R_WB.
  - lw: states 0,1,2,3,4,0.
  - instr_count=2.
- sw with mem_ready low for 3 cycles in MEM_WRITE:
  - mem_write stays high 4 cycles; total 7 cycles.
  - instr_count increments exactly once.
- beq then j:
  - BRANCH drives pc_write_cond=1, alu_op=01, pc_source=01.
  - JUMP drives pc_write=1, pc_source=10.
  - 3 cycles each.
- opcode=111111 in DECODE:
  - state goes to 13 and illegal=1; all strobes stay 0 for 20 cycles.
  - Reset clears illegal.
- halt=1 in FETCH with mem_ready=1:
  - No ir_write; HALTED the next cycle.
  - Deassert halt → FETCH → normal fetch.
- Preload instr_count near wrap (INSTR_CNT_W=4) and retire 17 instructions → instr_count=1. Also assert reset during MEM_READ → state=0 and count=0 asynchronously.
